apb_slave_asynch: RTL and testbench

Destination-clock-domain end of the asynchronous APB bridge. Accepts a transfer from the `asynch_req_i` / `asynch_ack_o` 4-phase handshake plus its quasi-static bus bundle, then replays it as a standard two-phase APB transfer on its local APB master port. It captures `PRDATA` and `PSLVERR`, and returns them with the acknowledge. It pairs with the source-side bridge, which raises req and holds the bundle stable until it sees ack.

---
 rtl/apb_async_pkg.sv | 16 +
 rtl/cdc_sync_bit.sv | 29 ++
 rtl/apb_slave_asynch.sv | 178 +++++++++++++++++
 tb/tb_apb_slave_asynch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_async_pkg.sv
// Shared definitions for both ends of the asynchronous APB bridge:
// handshake FSM states, default bus widths and the synchronizer depth floor.
package apb_async_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } apb_async_state_e;

    localparam int APB_DATA_WIDTH_DEF = 32;
    localparam int APB_ADDR_WIDTH_DEF = 32;
    localparam int SYNC_STAGES_MIN    = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer, cleared to 0 on reset.
// Depth requests below the metastability floor are raised to that floor.
module cdc_sync_bit
    import apb_async_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int DEPTH = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [DEPTH-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[DEPTH-2:0], d};
        end
    end

    assign q = sync_r[DEPTH-1];

endmodule

// File: rtl/apb_slave_asynch.sv
// Destination end of the asynchronous APB bridge: takes a transfer off the
// 4-phase req/ack handshake, replays it on the local APB port, returns the response.
module apb_slave_asynch
    import apb_async_pkg::*;
#(
    parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_MIN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      asynch_req_i,
    output logic                      asynch_ack_o,
    input  logic [APB_ADDR_WIDTH-1:0] async_PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0] async_PWDATA_i,
    input  logic                      async_PWRITE_i,
    input  logic                      async_PSEL_i,
    output logic [APB_DATA_WIDTH-1:0] async_PRDATA_o,
    output logic                      async_PSLVERR_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
    output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
    output logic                      PWRITE_o,
    output logic                      PSEL_o,
    output logic                      PENABLE_o,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
    input  logic                      PREADY_i,
    input  logic                      PSLVERR_i
);

    logic                      req_s;
    apb_async_state_e          state_r, state_nxt_s;
    logic                      ack_r, ack_nxt_s;
    logic                      psel_r, psel_nxt_s;
    logic                      penable_r, penable_nxt_s;
    logic                      pwrite_r, pwrite_nxt_s;
    logic [APB_ADDR_WIDTH-1:0] paddr_r, paddr_nxt_s;
    logic [APB_DATA_WIDTH-1:0] pwdata_r, pwdata_nxt_s;
    logic [APB_DATA_WIDTH-1:0] prdata_r, prdata_nxt_s;
    logic                      pslverr_r, pslverr_nxt_s;

    // Only the request is synchronized; the bundle is quasi-static once req_s is seen.
    cdc_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (asynch_req_i),
        .q    (req_s)
    );

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ack_r     <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r  <= {APB_DATA_WIDTH{1'b0}};
            prdata_r  <= {APB_DATA_WIDTH{1'b0}};
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ack_r     <= ack_nxt_s;
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            prdata_r  <= prdata_nxt_s;
            pslverr_r <= pslverr_nxt_s;
        end
    end

    // Next-state: ACK only exits on a low request, so a stale high req cannot retrigger.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = async_PSEL_i ? ST_SETUP : ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY_i) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the output registers.
    always_comb begin
        ack_nxt_s     = ack_r;
        psel_nxt_s    = psel_r;
        penable_nxt_s = penable_r;
        pwrite_nxt_s  = pwrite_r;
        paddr_nxt_s   = paddr_r;
        pwdata_nxt_s  = pwdata_r;
        prdata_nxt_s  = prdata_r;
        pslverr_nxt_s = pslverr_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    paddr_nxt_s  = async_PADDR_i;
                    pwdata_nxt_s = async_PWDATA_i;
                    pwrite_nxt_s = async_PWRITE_i;
                    if (async_PSEL_i) begin
                        psel_nxt_s    = 1'b1;
                        penable_nxt_s = 1'b0;
                    end else begin
                        ack_nxt_s     = 1'b1;
                        pslverr_nxt_s = 1'b0;
                    end
                end else begin
                    ack_nxt_s = 1'b0;
                end
            end
            ST_SETUP: penable_nxt_s = 1'b1;
            ST_ACCESS: begin
                if (PREADY_i) begin
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    pslverr_nxt_s = PSLVERR_i;
                    ack_nxt_s     = 1'b1;
                    if (!pwrite_r) begin
                        prdata_nxt_s = PRDATA_i;
                    end else begin
                        prdata_nxt_s = prdata_r;
                    end
                end else begin
                    ack_nxt_s = 1'b0;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_nxt_s = 1'b0;
                end else begin
                    ack_nxt_s = 1'b1;
                end
            end
            default: begin
                ack_nxt_s     = 1'b0;
                psel_nxt_s    = 1'b0;
                penable_nxt_s = 1'b0;
                pwrite_nxt_s  = 1'b0;
                paddr_nxt_s   = {APB_ADDR_WIDTH{1'b0}};
                pwdata_nxt_s  = {APB_DATA_WIDTH{1'b0}};
                prdata_nxt_s  = {APB_DATA_WIDTH{1'b0}};
                pslverr_nxt_s = 1'b0;
            end
        endcase
    end

    assign asynch_ack_o    = ack_r;
    assign PSEL_o          = psel_r;
    assign PENABLE_o       = penable_r;
    assign PWRITE_o        = pwrite_r;
    assign PADDR_o         = paddr_r;
    assign PWDATA_o        = pwdata_r;
    assign async_PRDATA_o  = prdata_r;
    assign async_PSLVERR_o = pslverr_r;

endmodule

// File: tb/tb_apb_slave_asynch.sv
// Self-checking bench for apb_slave_asynch: a transaction-timeline model predicts every
// output each cycle, plus literal checks of latencies and captured data.
module tb_apb_slave_asynch;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          asynch_req_i = 1'b0;
    logic          asynch_ack_o;
    logic [AW-1:0] async_PADDR_i = '0;
    logic [DW-1:0] async_PWDATA_i = '0;
    logic          async_PWRITE_i = 1'b0;
    logic          async_PSEL_i = 1'b0;
    logic [DW-1:0] async_PRDATA_o;
    logic          async_PSLVERR_o;
    logic [AW-1:0] PADDR_o;
    logic [DW-1:0] PWDATA_o;
    logic          PWRITE_o;
    logic          PSEL_o;
    logic          PENABLE_o;
    logic [DW-1:0] PRDATA_i = '0;
    logic          PREADY_i = 1'b0;
    logic          PSLVERR_i = 1'b0;

    // Expected outputs, valid after the next rising edge.
    logic          exp_ack = 1'b0, exp_psel = 1'b0, exp_penable = 1'b0, exp_pwrite = 1'b0;
    logic          exp_pslverr = 1'b0;
    logic [AW-1:0] exp_paddr = '0;
    logic [DW-1:0] exp_pwdata = '0, exp_prdata = '0;

    int checks = 0;
    int failures = 0;
    int pe, ne, ae;

    always #5 clk = ~clk;

    apb_slave_asynch #(
        .APB_DATA_WIDTH(DW),
        .APB_ADDR_WIDTH(AW),
        .SYNC_STAGES   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .asynch_req_i   (asynch_req_i),
        .asynch_ack_o   (asynch_ack_o),
        .async_PADDR_i  (async_PADDR_i),
        .async_PWDATA_i (async_PWDATA_i),
        .async_PWRITE_i (async_PWRITE_i),
        .async_PSEL_i   (async_PSEL_i),
        .async_PRDATA_o (async_PRDATA_o),
        .async_PSLVERR_o(async_PSLVERR_o),
        .PADDR_o        (PADDR_o),
        .PWDATA_o       (PWDATA_o),
        .PWRITE_o       (PWRITE_o),
        .PSEL_o         (PSEL_o),
        .PENABLE_o      (PENABLE_o),
        .PRDATA_i       (PRDATA_i),
        .PREADY_i       (PREADY_i),
        .PSLVERR_i      (PSLVERR_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("ack", 64'(asynch_ack_o), 64'(exp_ack));
            chk("psel", 64'(PSEL_o), 64'(exp_psel));
            chk("penable", 64'(PENABLE_o), 64'(exp_penable));
            chk("pwrite", 64'(PWRITE_o), 64'(exp_pwrite));
            chk("paddr", 64'(PADDR_o), 64'(exp_paddr));
            chk("pwdata", 64'(PWDATA_o), 64'(exp_pwdata));
            chk("prdata", 64'(async_PRDATA_o), 64'(exp_prdata));
            chk("pslverr", 64'(async_PSLVERR_o), 64'(exp_pslverr));
        end
    end

    task automatic noise();
        PRDATA_i  = $urandom;
        PSLVERR_i = 1'($urandom_range(0, 1));
        PREADY_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic scramble_bundle();
        async_PADDR_i  = $urandom;
        async_PWDATA_i = $urandom;
        async_PWRITE_i = 1'($urandom_range(0, 1));
        async_PSEL_i   = 1'($urandom_range(0, 1));
    endtask

    // One handshake; step k drives just before edge k counted from the req rise.
    task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic wr, input logic sel, input int waits,
                        input logic [DW-1:0] rdata, input logic err, input int hold,
                        output int psel_e, output int pen_e, output int ack_e);
        int ack_k;
        psel_e = -1;
        pen_e  = -1;
        ack_e  = -1;
        ack_k  = sel ? 5 + waits : 3;
        for (int k = 1; k <= ack_k + hold + 3; k++) begin
            @(negedge clk);
            if (PSEL_o === 1'b1 && psel_e < 0) psel_e = k - 1;
            if (PENABLE_o === 1'b1 && pen_e < 0) pen_e = k - 1;
            if (asynch_ack_o === 1'b1 && ack_e < 0) ack_e = k - 1;
            noise();
            if (k == 1) begin
                rst_n          = 1'b1;
                asynch_req_i   = 1'b1;
                async_PADDR_i  = addr;
                async_PWDATA_i = wdata;
                async_PWRITE_i = wr;
                async_PSEL_i   = sel;
            end
            if (k == ack_k + hold + 1) begin
                asynch_req_i = 1'b0;
                scramble_bundle();
            end
            if (sel && k >= 5 && k <= ack_k) begin
                PREADY_i = (k == ack_k);
                PRDATA_i = rdata;
                if (k == ack_k) PSLVERR_i = err;
            end
            if (k == 3) begin
                exp_paddr  = addr;
                exp_pwdata = wdata;
                exp_pwrite = wr;
                if (sel) begin
                    exp_psel = 1'b1;
                end else begin
                    exp_ack     = 1'b1;
                    exp_pslverr = 1'b0;
                end
            end
            if (sel && k == 4) exp_penable = 1'b1;
            if (sel && k == ack_k) begin
                exp_psel    = 1'b0;
                exp_penable = 1'b0;
                exp_ack     = 1'b1;
                exp_pslverr = err;
                if (!wr) exp_prdata = rdata;
            end
            if (k == ack_k + hold + 3) exp_ack = 1'b0;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(asynch_ack_o), 64'd0);
        chk("rst_psel", 64'(PSEL_o), 64'd0);
        chk("rst_prdata", 64'(async_PRDATA_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait read.
        xfer(32'h1000_0004, 32'h0, 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 1, pe, ne, ae);
        chk("rd_psel_edge", 64'(pe), 64'd3);
        chk("rd_penable_edge", 64'(ne), 64'd4);
        chk("rd_ack_edge", 64'(ae), 64'd5);
        chk("rd_prdata", 64'(async_PRDATA_o), 64'hDEAD_BEEF);
        chk("rd_pslverr", 64'(async_PSLVERR_o), 64'd0);

        // Write with three wait states keeps the old read data.
        xfer(32'h2000_0008, 32'h1234_5678, 1'b1, 1'b1, 3, 32'h5555_AAAA, 1'b0, 2, pe, ne, ae);
        chk("wr_ack_edge", 64'(ae), 64'd8);
        chk("wr_keeps_prdata", 64'(async_PRDATA_o), 64'hDEAD_BEEF);

        // Error response.
        xfer(32'h3000_0000, 32'h0, 1'b0, 1'b1, 1, 32'hCAFE_F00D, 1'b1, 1, pe, ne, ae);
        chk("err_pslverr", 64'(async_PSLVERR_o), 64'd1);
        chk("err_prdata", 64'(async_PRDATA_o), 64'hCAFE_F00D);

        // Req held long after ack, then a fresh transfer.
        xfer(32'h4000_0010, 32'h0, 1'b0, 1'b1, 0, 32'h0BAD_CAFE, 1'b0, 10, pe, ne, ae);
        xfer(32'h4000_0014, 32'h0, 1'b0, 1'b1, 0, 32'h1111_2222, 1'b0, 1, pe, ne, ae);
        chk("b2b_second_ack", 64'(ae), 64'd5);
        chk("b2b_prdata", 64'(async_PRDATA_o), 64'h1111_2222);

        // No select: handshake completes without a local transfer.
        xfer(32'h5000_0000, 32'h0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1, pe, ne, ae);
        chk("nosel_psel", 64'(pe), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("nosel_ack_edge", 64'(ae), 64'd3);
        chk("nosel_pslverr", 64'(async_PSLVERR_o), 64'd0);

        // Reset while stalled in ACCESS, req still high afterwards.
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            noise();
            if (k == 1) begin
                asynch_req_i   = 1'b1;
                async_PADDR_i  = 32'h6000_0020;
                async_PWDATA_i = 32'h0;
                async_PWRITE_i = 1'b0;
                async_PSEL_i   = 1'b1;
            end
            if (k >= 5) PREADY_i = 1'b0;
            if (k == 3) begin
                exp_psel   = 1'b1;
                exp_paddr  = 32'h6000_0020;
                exp_pwdata = 32'h0;
                exp_pwrite = 1'b0;
            end
            if (k == 4) exp_penable = 1'b1;
        end
        @(negedge clk);
        PREADY_i    = 1'b0;
        rst_n       = 1'b0;
        exp_ack     = 1'b0;
        exp_psel    = 1'b0;
        exp_penable = 1'b0;
        exp_pwrite  = 1'b0;
        exp_paddr   = '0;
        exp_pwdata  = '0;
        exp_prdata  = '0;
        exp_pslverr = 1'b0;
        @(negedge clk);
        chk("rst_mid_psel", 64'(PSEL_o), 64'd0);
        chk("rst_mid_paddr", 64'(PADDR_o), 64'd0);
        xfer(32'h6000_0020, 32'h0, 1'b0, 1'b1, 2, 32'h7777_8888, 1'b0, 1, pe, ne, ae);
        chk("rst_restart_psel_edge", 64'(pe), 64'd3);
        chk("rst_restart_ack_edge", 64'(ae), 64'd7);

        // Randomized transfers.
        for (int t = 0; t < 40; t++) begin
            xfer($urandom, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), pe, ne, ae);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(negedge clk);
                noise();
                scramble_bundle();
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
